pdm_dac: RTL and testbench

- First-order sigma-delta (pulse-density) DAC stage that sits directly downstream of the NCO.
- Consumes the NCO's unsigned 10-bit sample stream through a one-deep valid/ready buffer and re-samples it at a fixed update rate.
- Produces a 1-bit density-modulated output for a GPIO pin followed by an external RC low-pass filter.
- Also flags sample underruns.

---
 rtl/pdm_dac.sv | 146 ++++++++++++++
 tb/tb_pdm_dac.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_dac.sv
// ---------------------------------------------------------------------------
// pdm_dac
//   First-order sigma-delta (pulse-density) DAC stage fed by the NCO.
//   Samples arrive through a one-deep valid/ready buffer and are re-sampled
//   into the modulator once every UPD_DIV clocks. The carry-out of a
//   DATA_W-bit phase accumulator is the 1-bit density output, intended for a
//   GPIO pin followed by an external RC low-pass filter.
//
//   Optional build macro: PDM_DAC_DITHER_EN
//     Defined   : a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11, seed 16'hACE1)
//                 supplies the accumulator carry-in to break idle tones.
//     Undefined : carry-in is tied low; no LFSR logic is built.
//
// Parameters
//   DATA_W  - sample width, unsigned offset-binary (density = S / 2^DATA_W)
//   UPD_DIV - clocks per modulator sample update (2..65535)
//   CNT_W   - update-divider counter width (2^CNT_W >= UPD_DIV)
//
// Ports
//   i_clk          - system clock
//   i_rst          - synchronous active-high reset
//   i_valid        - upstream sample valid
//   i_data         - upstream sample
//   o_ready        - pending buffer empty (registered)
//   o_upd          - one-cycle strobe per modulator sample update
//   o_underrun     - sticky: an update found the pending buffer empty
//   i_clr_underrun - clears o_underrun (a coincident underrun set wins)
//   o_pdm          - registered pulse-density output
// ---------------------------------------------------------------------------
module pdm_dac #(
    parameter int DATA_W  = 10,
    parameter int UPD_DIV = 64,
    parameter int CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_upd,
    output logic              o_underrun,
    input  logic              i_clr_underrun,
    output logic              o_pdm
);

    localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(UPD_DIV - 1);
    localparam logic [DATA_W-1:0] MID_SCALE = DATA_W'(2 ** (DATA_W - 1));

    logic [CNT_W-1:0]  div_cnt;
    logic              tick;
    logic              accept;
    logic [DATA_W-1:0] pend_data;
    logic [DATA_W-1:0] active;
    logic [DATA_W-1:0] acc;
    logic [DATA_W:0]   acc_sum;
    logic              cin;

    // o_ready doubles as the "buffer empty" state bit, so it is registered
    // and has no combinational dependence on i_valid.
    assign tick   = (div_cnt == DIV_LAST);
    assign accept = i_valid && o_ready;

    // -----------------------------------------------------------------------
    // Update divider: 0 .. UPD_DIV-1, tick on the last count.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Pending buffer, active sample and underrun flag.
    // A tick with a full buffer hands the sample over; while full, o_ready is
    // low so no capture can collide with the hand-off. A tick with an empty
    // buffer may coincide with an accept: the tick holds the old sample and
    // the new one waits in the buffer for the following tick.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ready    <= 1'b1;
            pend_data  <= '0;
            active     <= MID_SCALE;
            o_upd      <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            o_upd <= tick;

            if (tick && !o_ready) begin
                active  <= pend_data;
                o_ready <= 1'b1;
            end else if (accept) begin
                pend_data <= i_data;
                o_ready   <= 1'b0;
            end

            if (tick && o_ready) begin
                o_underrun <= 1'b1;
            end else if (i_clr_underrun) begin
                o_underrun <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Carry-in source.
    // -----------------------------------------------------------------------
`ifdef PDM_DAC_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign cin = lfsr[0];
`else
    assign cin = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // First-order modulator: the carry-out is the output bit and the
    // accumulator simply wraps, so no saturation is needed.
    // -----------------------------------------------------------------------
    always_comb begin
        acc_sum = {1'b0, acc} + {1'b0, active} + {{DATA_W{1'b0}}, cin};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc   <= '0;
            o_pdm <= 1'b0;
        end else begin
            acc   <= acc_sum[DATA_W-1:0];
            o_pdm <= acc_sum[DATA_W];
        end
    end

endmodule

// File: tb/tb_pdm_dac.sv
// ---------------------------------------------------------------------------
// tb_pdm_dac
//   Self-checking bench for pdm_dac. A behavioural reference model tracks the
//   buffer as a queue and the modulator as an unbounded running sum whose
//   2^DATA_W boundary crossings are the output pulses; every clock it is
//   compared against all DUT outputs. Density windows, back-pressure and
//   tick/accept corner cases are also checked explicitly.
// ---------------------------------------------------------------------------
module tb_pdm_dac;

    localparam int DATA_W  = 10;
    localparam int UPD_DIV = 64;
    localparam int CNT_W   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              clr;
    logic              ready;
    logic              upd;
    logic              underrun;
    logic              pdm;

    always #5 clk = ~clk;

    pdm_dac #(
        .DATA_W (DATA_W),
        .UPD_DIV(UPD_DIV),
        .CNT_W  (CNT_W)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_valid       (valid),
        .i_data        (data),
        .o_ready       (ready),
        .o_upd         (upd),
        .o_underrun    (underrun),
        .i_clr_underrun(clr),
        .o_pdm         (pdm)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    int unsigned q[$];
    int unsigned m_active;
    longint      m_sum;
    int          m_cnt;
    bit          m_pdm, m_upd, m_und;
`ifdef PDM_DAC_DITHER_EN
    bit [15:0]   m_lfsr;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit     empty;
        bit     tick;
        int     cin;
        longint new_sum;
        if (rst) begin
            q.delete();
            m_active = 1 << (DATA_W - 1);
            m_sum    = 0;
            m_cnt    = 0;
            m_pdm    = 0;
            m_upd    = 0;
            m_und    = 0;
`ifdef PDM_DAC_DITHER_EN
            m_lfsr   = 16'hACE1;
`endif
        end else begin
            empty = (q.size() == 0);
            tick  = (m_cnt == UPD_DIV - 1);
            cin   = 0;
`ifdef PDM_DAC_DITHER_EN
            cin    = m_lfsr[0];
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
            new_sum = m_sum + m_active + cin;
            m_pdm   = (new_sum >> DATA_W) != (m_sum >> DATA_W);
            m_sum   = new_sum;
            m_cnt   = tick ? 0 : m_cnt + 1;
            m_upd   = tick;
            if (tick && empty) m_und = 1;
            else if (clr)      m_und = 0;
            if (tick && !empty) m_active = q.pop_front();
            if (valid && empty) q.push_back(data);
        end
    endtask

    // One clock: model follows the same edge, outputs compared 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("m_ready",    ready,    (q.size() == 0));
        check("m_upd",      upd,      m_upd);
        check("m_underrun", underrun, m_und);
        check("m_pdm",      pdm,      m_pdm);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Steps until o_upd is seen; k = edges taken. Expiry is a failed check.
    task automatic wait_upd(input int bound, output int k);
        k = 0;
        do begin
            step();
            k++;
        end while (upd !== 1'b1 && k < bound);
        check("upd_seen", upd, 1);
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        repeat (n) begin
            step();
            if (pdm === 1'b1) ones++;
        end
    endtask

    typedef struct {
        int unsigned s;
        int          exp_ones;
    } dens_vec_t;

    initial begin
        dens_vec_t   vecs[6];
        int          k, ones, acc_cnt, mism;
        int unsigned cap;
        bit          bits[1024];

        vecs[0] = '{0,    0};
        vecs[1] = '{1,    1};
        vecs[2] = '{256,  256};
        vecs[3] = '{512,  512};
        vecs[4] = '{900,  900};
        vecs[5] = '{1023, 1023};

        rst = 1'b1; valid = 1'b0; data = '0; clr = 1'b0;
        step();

        // ---- reset release, no input ----
        do_reset();
        check("rst_ready", ready, 1);
        check("rst_pdm", pdm, 0);
        check("rst_upd", upd, 0);
        check("rst_underrun", underrun, 0);
`ifndef PDM_DAC_DITHER_EN
        step(); check("mid_pdm0", pdm, 0);
        step(); check("mid_pdm1", pdm, 1);
        step(); check("mid_pdm2", pdm, 0);
`endif
        wait_upd(200, k);
        check("first_underrun", underrun, 1);
        wait_upd(200, k);
        check("upd_period", k, UPD_DIV);
        clr = 1'b1; step(); clr = 1'b0;
        check("clr_underrun", underrun, 0);
        run(UPD_DIV - 2);
        clr = 1'b1; step(); clr = 1'b0;
        check("set_wins_upd", upd, 1);
        check("set_wins_underrun", underrun, 1);

        // ---- constant feed S=256, pattern and cleared underrun ----
        do_reset();
        valid = 1'b1; data = 10'd256;
        run(200);
        clr = 1'b1; step(); clr = 1'b0;
        ones = 0;
        for (int i = 0; i < 1024; i++) begin
            step();
            bits[i] = pdm;
            if (pdm === 1'b1) ones++;
        end
        check("feed256_underrun", underrun, 0);
`ifndef PDM_DAC_DITHER_EN
        check("feed256_ones", ones, 256);
        mism = 0;
        for (int i = 0; i < 1020; i++) if (bits[i] != bits[i+4]) mism++;
        check("feed256_period4", mism, 0);
`endif

        // ---- table: constant-sample density ----
`ifndef PDM_DAC_DITHER_EN
        for (int v = 0; v < 6; v++) begin
            do_reset();
            valid = 1'b1; data = DATA_W'(vecs[v].s);
            run(200);
            count_ones(1024, ones);
            check($sformatf("density_%0d", vecs[v].s), ones, vecs[v].exp_ones);
        end
`endif
        valid = 1'b0;

        // ---- back-pressure: data changes every clock ----
        do_reset();
        valid = 1'b1;
        acc_cnt = 0; cap = 0; k = 0;
        do begin
            data = DATA_W'($urandom);
            if (ready === 1'b1) begin
                acc_cnt++;
                cap = data;
            end
            step();
            k++;
            if (k == 1) check("bp_ready_low", ready, 0);
        end while (upd !== 1'b1 && k < 200);
        valid = 1'b0;
        check("bp_upd_seen", upd, 1);
        check("bp_accepts", acc_cnt, 1);
        check("bp_ready_after_tick", ready, 1);
        run(2);
        count_ones(1024, ones);
`ifndef PDM_DAC_DITHER_EN
        check("bp_captured_density", ones, cap);
`endif

        // ---- simultaneous tick + accept with the buffer empty ----
        do_reset();
        run(UPD_DIV - 1);
        valid = 1'b1; data = 10'd100;
        step();
        valid = 1'b0;
        check("ta_upd", upd, 1);
        check("ta_underrun", underrun, 1);
        check("ta_ready", ready, 0);
        run(UPD_DIV - 1);
        check("ta_still_full", ready, 0);
        step();
        check("ta_load_upd", upd, 1);
        check("ta_load_ready", ready, 1);
        run(2);
        count_ones(1024, ones);
`ifndef PDM_DAC_DITHER_EN
        check("ta_density", ones, 100);
`endif

        // ---- reset mid-stream ----
        do_reset();
        valid = 1'b1; data = 10'd900;
        run(150);
        check("ms_full", ready, 0);
        valid = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        check("ms_ready", ready, 1);
        check("ms_pdm", pdm, 0);
        check("ms_underrun", underrun, 0);
        count_ones(1024, ones);
`ifndef PDM_DAC_DITHER_EN
        check("ms_density", ones, 512);
`endif

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 4000; i++) begin
            valid = ($urandom_range(0, 3) == 0);
            data  = DATA_W'($urandom);
            clr   = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0; valid = 1'b0; clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
